// File: rtl/misr_pkg.sv
// Shared definitions for the multi-channel MISR signature unit:
// FSM state encoding, CSR word offsets, CTRL/STATUS bit positions and
// the per-channel register layout.
package misr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // CSR word offsets relative to the window base
    localparam int unsigned OFF_CTRL   = 32'h00;
    localparam int unsigned OFF_STATUS = 32'h04;
    localparam int unsigned OFF_LENGTH = 32'h08;
    localparam int unsigned OFF_CH_EN  = 32'h0C;
    localparam int unsigned OFF_COUNT  = 32'h10;

    // Channel c lives at CH_BASE + CH_STRIDE*c
    localparam int unsigned CH_BASE   = 32'h20;
    localparam int unsigned CH_STRIDE = 32'h10;

    // Word index inside a channel block (offset bits [3:2])
    localparam logic [1:0] CH_SUB_COEFF = 2'd0;
    localparam logic [1:0] CH_SUB_SEED  = 2'd1;
    localparam logic [1:0] CH_SUB_SIG   = 2'd2;

    localparam int unsigned CTRL_START_BIT  = 0;
    localparam int unsigned CTRL_CLEAR_BIT  = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT = 2;
    localparam int unsigned STATUS_DONE_BIT = 2;

endpackage

// File: rtl/misr_lane.sv
// One MISR channel: holds the signature register.
// Ports:
//   clk_i, rst_ni   clock and async active-low reset
//   clear_i         force signature to 0 (highest priority)
//   load_i          load signature from seed_i
//   step_i          advance one Galois step with coeff_i / data_i
//   seed_i, coeff_i, data_i   per-channel operands
//   sig_o           current signature
module misr_lane #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic         step_i,
    input  logic [W-1:0] seed_i,
    input  logic [W-1:0] coeff_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] sig_o
);

    logic [W-1:0] sig_q;
    logic [W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clear_i) begin
            sig_d = '0;
        end else if (load_i) begin
            sig_d = seed_i;
        end else if (step_i) begin
            // Galois shift: MSB feeds back through the polynomial taps
            sig_d = {sig_q[W-2:0], 1'b0} ^ ({W{sig_q[W-1]}} & coeff_i) ^ data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/misr_multichannel_ctrl.sv
// Memory-mapped multi-channel signature unit.
// Compresses N_CH parallel data streams into per-channel MISR signatures
// over a programmable number of samples, with a control/status FSM,
// sticky done flag and done interrupt.
// Ports:
//   clk_i, rst_ni      clock and async active-low reset
//   re_i, we_i         CSR read / write request
//   addr_i             CSR byte address
//   data_csr_i         CSR write data
//   data_csr_o         CSR read data (combinational, 0 when not reading)
//   misr_data_i        channel c at [c*NBIT_DATA +: NBIT_DATA]
//   misr_valid_i       sample strobe shared by all channels
//   irq_o              done interrupt
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | cleared / after reset; waiting for START
// ST_RUN  | accepting samples until COUNT reaches LENGTH
// ST_DONE | run finished; signatures and COUNT frozen until START/CLEAR
module misr_multichannel_ctrl
    import misr_pkg::*;
#(
    parameter int unsigned            NBIT_DATA  = 32,
    parameter int unsigned            NBIT_ADDR  = 32,
    parameter int unsigned            N_CH       = 4,
    parameter int unsigned            CNT_W      = 16,
    parameter logic [NBIT_ADDR-1:0]   START_ADDR = NBIT_ADDR'(2**25)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      re_i,
    input  logic                      we_i,
    input  logic [NBIT_ADDR-1:0]      addr_i,
    input  logic [NBIT_DATA-1:0]      data_csr_i,
    output logic [NBIT_DATA-1:0]      data_csr_o,
    input  logic [N_CH*NBIT_DATA-1:0] misr_data_i,
    input  logic                      misr_valid_i,
    output logic                      irq_o
);

    state_e                 state_q;
    logic                   done_q;
    logic                   irq_en_q;
    logic [CNT_W-1:0]       length_q;
    logic [CNT_W-1:0]       count_q;
    logic [N_CH-1:0]        ch_en_q;
    logic [NBIT_DATA-1:0]   coeff_q [N_CH];
    logic [NBIT_DATA-1:0]   seed_q  [N_CH];
    logic [NBIT_DATA-1:0]   sig     [N_CH];

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [NBIT_ADDR-1:0] off;
    logic                 in_win;
    logic                 hit_ctrl, hit_status, hit_length, hit_ch_en, hit_count;
    logic                 hit_ch;
    logic [2:0]           ch_sel;
    logic [1:0]           ch_sub;

    assign off        = addr_i - START_ADDR;
    assign in_win     = (addr_i >= START_ADDR) && (off[1:0] == 2'b00);
    assign hit_ctrl   = in_win && (off == NBIT_ADDR'(OFF_CTRL));
    assign hit_status = in_win && (off == NBIT_ADDR'(OFF_STATUS));
    assign hit_length = in_win && (off == NBIT_ADDR'(OFF_LENGTH));
    assign hit_ch_en  = in_win && (off == NBIT_ADDR'(OFF_CH_EN));
    assign hit_count  = in_win && (off == NBIT_ADDR'(OFF_COUNT));
    assign hit_ch     = in_win && (off >= NBIT_ADDR'(CH_BASE))
                        && (off < NBIT_ADDR'(CH_BASE + CH_STRIDE * N_CH));
    // Channel blocks start at 0x20, so offset bits [6:4] minus 2 give the
    // channel number for up to 8 channels (wraps cleanly for 0x90).
    assign ch_sel     = off[6:4] - 3'd2;
    assign ch_sub     = off[3:2];

    // ------------------------------------------------------------------
    // Control strobes
    // ------------------------------------------------------------------
    logic             wr_ctrl;
    logic             clear_req;
    logic             start_acc;
    logic             done_clr;
    logic             sample;
    logic [CNT_W-1:0] count_inc;

    assign wr_ctrl   = we_i && hit_ctrl;
    assign clear_req = wr_ctrl && data_csr_i[CTRL_CLEAR_BIT];
    // CLEAR wins over START in the same write; START while running is ignored
    assign start_acc = wr_ctrl && data_csr_i[CTRL_START_BIT] && !clear_req
                       && (state_q != ST_RUN);
    assign done_clr  = we_i && hit_status && data_csr_i[STATUS_DONE_BIT];
    assign sample    = (state_q == ST_RUN) && misr_valid_i && !clear_req;
    assign count_inc = count_q + 1'b1;

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_en_q <= 1'b0;
            length_q <= '0;
            ch_en_q  <= '0;
            for (int c = 0; c < N_CH; c++) begin
                coeff_q[c] <= '0;
                seed_q[c]  <= '0;
            end
        end else if (we_i) begin
            if (hit_ctrl) begin
                irq_en_q <= data_csr_i[CTRL_IRQ_EN_BIT];
            end
            if (hit_length) begin
                length_q <= data_csr_i[CNT_W-1:0];
            end
            if (hit_ch_en) begin
                ch_en_q <= data_csr_i[N_CH-1:0];
            end
            for (int c = 0; c < N_CH; c++) begin
                if (hit_ch && (ch_sel == 3'(c))) begin
                    if (ch_sub == CH_SUB_COEFF) coeff_q[c] <= data_csr_i;
                    if (ch_sub == CH_SUB_SEED)  seed_q[c]  <= data_csr_i;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM, sample counter and sticky done flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else if (clear_req) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else if (start_acc) begin
            count_q <= '0;
            if (length_q == '0) begin
                // Zero-length run completes immediately with SIG = SEED
                state_q <= ST_DONE;
                done_q  <= 1'b1;
            end else begin
                state_q <= ST_RUN;
                done_q  <= 1'b0;
            end
        end else begin
            if (sample) begin
                count_q <= count_inc;
                // Compare against the live LENGTH so mid-run edits apply
                if (count_inc == length_q) begin
                    state_q <= ST_DONE;
                end
            end
            // A completion on the same edge as a clear-write keeps DONE set
            if (sample && (count_inc == length_q)) begin
                done_q <= 1'b1;
            end else if (done_clr) begin
                done_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Signature lanes
    // ------------------------------------------------------------------
    for (genvar g = 0; g < N_CH; g++) begin : g_lane
        misr_lane #(
            .W(NBIT_DATA)
        ) u_lane (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .clear_i (clear_req),
            .load_i  (start_acc),
            .step_i  (sample && ch_en_q[g]),
            .seed_i  (seed_q[g]),
            .coeff_i (coeff_q[g]),
            .data_i  (misr_data_i[g*NBIT_DATA +: NBIT_DATA]),
            .sig_o   (sig[g])
        );
    end

    // ------------------------------------------------------------------
    // Combinational read mux; a simultaneous write suppresses the read
    // ------------------------------------------------------------------
    logic [NBIT_DATA-1:0] rdata;

    always_comb begin
        rdata = '0;
        if (re_i && !we_i) begin
            if (hit_ctrl) begin
                rdata[CTRL_IRQ_EN_BIT] = irq_en_q;
            end else if (hit_status) begin
                rdata[1:0]             = state_q;
                rdata[STATUS_DONE_BIT] = done_q;
            end else if (hit_length) begin
                rdata[CNT_W-1:0] = length_q;
            end else if (hit_ch_en) begin
                rdata[N_CH-1:0] = ch_en_q;
            end else if (hit_count) begin
                rdata[CNT_W-1:0] = count_q;
            end else if (hit_ch) begin
                for (int c = 0; c < N_CH; c++) begin
                    if (ch_sel == 3'(c)) begin
                        case (ch_sub)
                            CH_SUB_COEFF: rdata = coeff_q[c];
                            CH_SUB_SEED:  rdata = seed_q[c];
                            CH_SUB_SIG:   rdata = sig[c];
                            default:      rdata = '0;
                        endcase
                    end
                end
            end
        end
    end

    assign data_csr_o = rdata;
    assign irq_o      = done_q & irq_en_q;

endmodule

// File: tb/tb_misr_multichannel_ctrl.sv
module tb_misr_multichannel_ctrl;

    localparam logic [31:0] BASE = 32'h0200_0000;
    localparam logic [31:0] A_CTRL = 32'h00, A_STATUS = 32'h04, A_LENGTH = 32'h08;
    localparam logic [31:0] A_CHEN = 32'h0C, A_COUNT = 32'h10;
    localparam logic [31:0] A_COEFF0 = 32'h20, A_SEED0 = 32'h24, A_SIG0 = 32'h28;
    localparam logic [31:0] A_COEFF1 = 32'h30, A_SEED1 = 32'h34, A_SIG1 = 32'h38;
    localparam logic [31:0] POLY = 32'h04C1_1DB7;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         re_i, we_i;
    logic [31:0]  addr_i;
    logic [31:0]  data_csr_i;
    logic [31:0]  data_csr_o;
    logic [127:0] misr_data_i;
    logic         misr_valid_i;
    logic         irq_o;

    int checks   = 0;
    int failures = 0;

    misr_multichannel_ctrl dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .re_i         (re_i),
        .we_i         (we_i),
        .addr_i       (addr_i),
        .data_csr_i   (data_csr_i),
        .data_csr_o   (data_csr_o),
        .misr_data_i  (misr_data_i),
        .misr_valid_i (misr_valid_i),
        .irq_o        (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        @(negedge clk_i);
        addr_i = BASE + off; data_csr_i = d; we_i = 1'b1;
        @(negedge clk_i);
        we_i = 1'b0;
    endtask

    task automatic rd(input logic [31:0] off, output logic [31:0] d);
        @(negedge clk_i);
        addr_i = BASE + off; re_i = 1'b1;
        #1 d = data_csr_o;
        re_i = 1'b0;
    endtask

    // n consecutive accepted-sample cycles with the given channel-0/1 data
    task automatic pulse_valid(input int n, input logic [31:0] d0, input logic [31:0] d1);
        @(negedge clk_i);
        misr_data_i = '0; misr_data_i[31:0] = d0; misr_data_i[63:32] = d1;
        misr_valid_i = 1'b1;
        repeat (n) @(negedge clk_i);
        misr_valid_i = 1'b0; misr_data_i = '0;
    endtask

    task automatic test_reset();
        logic [31:0] offs [17];
        logic [31:0] v;
        offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10,
                 32'h20, 32'h24, 32'h28, 32'h30, 32'h34, 32'h38,
                 32'h40, 32'h44, 32'h48, 32'h50, 32'h54, 32'h58};
        foreach (offs[i]) begin
            rd(offs[i], v);
            checks++;
            if (v !== 32'h0) begin
                failures++;
                $display("FAIL reset_reg off=%h got=%h exp=0", offs[i], v);
            end
        end
        checks++;
        if (irq_o !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq_o); end
    endtask

    task automatic test_single_step();
        logic [31:0] v;
        wr(A_COEFF0, POLY); wr(A_SEED0, 32'h8000_0000);
        wr(A_LENGTH, 32'd1); wr(A_CHEN, 32'h1); wr(A_CTRL, 32'h1);
        rd(A_CTRL, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL ctrl_start_reads0 got=%h exp=0", v); end
        pulse_valid(1, 32'h0, 32'h0);
        rd(A_SIG0, v);
        checks++;
        if (v !== POLY) begin failures++; $display("FAIL single_sig0 got=%h exp=%h", v, POLY); end
        rd(A_STATUS, v);
        checks++;
        if (v !== 32'h6) begin failures++; $display("FAIL single_status got=%h exp=6", v); end
        rd(A_COUNT, v);
        checks++;
        if (v !== 32'h1) begin failures++; $display("FAIL single_count got=%h exp=1", v); end
        // valid while DONE must be ignored
        pulse_valid(1, 32'hFFFF_FFFF, 32'h0);
        rd(A_SIG0, v);
        checks++;
        if (v !== POLY) begin failures++; $display("FAIL done_hold_sig got=%h exp=%h", v, POLY); end
        rd(A_COUNT, v);
        checks++;
        if (v !== 32'h1) begin failures++; $display("FAIL done_hold_count got=%h exp=1", v); end
    endtask

    task automatic test_disabled_channel();
        logic [31:0] v;
        wr(A_SEED0, 32'h0); wr(A_SEED1, 32'hA5A5_A5A5); wr(A_COEFF1, POLY);
        wr(A_CHEN, 32'h1); wr(A_CTRL, 32'h1);
        pulse_valid(1, 32'h1, 32'hFFFF_FFFF);
        rd(A_SIG0, v);
        checks++;
        if (v !== 32'h1) begin failures++; $display("FAIL dis_sig0 got=%h exp=1", v); end
        rd(A_SIG1, v);
        checks++;
        if (v !== 32'hA5A5_A5A5) begin failures++; $display("FAIL dis_sig1 got=%h exp=a5a5a5a5", v); end
    endtask

    task automatic test_gap_irq();
        logic [31:0] v;
        wr(A_SEED0, 32'h8000_0001); wr(A_LENGTH, 32'd3);
        wr(A_CTRL, 32'h5);
        checks++;
        if (irq_o !== 1'b0) begin failures++; $display("FAIL gap_irq_after_start got=%b exp=0", irq_o); end
        pulse_valid(2, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            #1;
            checks++;
            if (irq_o !== 1'b0) begin failures++; $display("FAIL gap_irq cyc=%0d got=%b exp=0", i, irq_o); end
        end
        rd(A_STATUS, v);
        checks++;
        if (v !== 32'h1) begin failures++; $display("FAIL gap_status got=%h exp=1", v); end
        rd(A_COUNT, v);
        checks++;
        if (v !== 32'h2) begin failures++; $display("FAIL gap_count got=%h exp=2", v); end
        pulse_valid(1, 32'h10, 32'h0);
        #1;
        checks++;
        if (irq_o !== 1'b1) begin failures++; $display("FAIL gap_irq_rise got=%b exp=1", irq_o); end
        // 80000001 -> 04c11db5 -> 09823b6a -> 130476d4^10
        rd(A_SIG0, v);
        checks++;
        if (v !== 32'h1304_76C4) begin failures++; $display("FAIL gap_sig0 got=%h exp=130476c4", v); end
        rd(A_STATUS, v);
        checks++;
        if (v !== 32'h6) begin failures++; $display("FAIL gap_status_done got=%h exp=6", v); end
        wr(A_STATUS, 32'h4);
        #1;
        checks++;
        if (irq_o !== 1'b0) begin failures++; $display("FAIL gap_irq_clear got=%b exp=0", irq_o); end
        rd(A_STATUS, v);
        checks++;
        if (v !== 32'h2) begin failures++; $display("FAIL gap_status_clr got=%h exp=2", v); end
    endtask

    task automatic test_len0_start_clear();
        logic [31:0] v;
        wr(A_SEED0, 32'h1234_5678); wr(A_LENGTH, 32'd0); wr(A_CTRL, 32'h1);
        rd(A_STATUS, v);
        checks++;
        if (v[1:0] !== 2'd2) begin failures++; $display("FAIL len0_state got=%0d exp=2", v[1:0]); end
        rd(A_SIG0, v);
        checks++;
        if (v !== 32'h1234_5678) begin failures++; $display("FAIL len0_sig got=%h exp=12345678", v); end
        wr(A_LENGTH, 32'd10); wr(A_CTRL, 32'h1);
        pulse_valid(2, 32'h0, 32'h0);
        wr(A_CTRL, 32'h1);
        pulse_valid(1, 32'h0, 32'h0);
        rd(A_COUNT, v);
        checks++;
        if (v !== 32'h3) begin failures++; $display("FAIL start_in_run_count got=%h exp=3", v); end
        rd(A_STATUS, v);
        checks++;
        if (v !== 32'h1) begin failures++; $display("FAIL start_in_run_status got=%h exp=1", v); end
        // live LENGTH lowered to the next count value ends the run there
        wr(A_LENGTH, 32'd4);
        pulse_valid(1, 32'h0, 32'h0);
        rd(A_STATUS, v);
        checks++;
        if (v !== 32'h6) begin failures++; $display("FAIL live_len_status got=%h exp=6", v); end
        rd(A_COUNT, v);
        checks++;
        if (v !== 32'h4) begin failures++; $display("FAIL live_len_count got=%h exp=4", v); end
        wr(A_LENGTH, 32'd10); wr(A_CTRL, 32'h1);
        pulse_valid(1, 32'h0, 32'h0);
        wr(A_CTRL, 32'h2);
        rd(A_STATUS, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL clear_status got=%h exp=0", v); end
        rd(A_SIG0, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL clear_sig0 got=%h exp=0", v); end
        rd(A_COUNT, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL clear_count got=%h exp=0", v); end
        wr(A_CTRL, 32'h3);
        rd(A_STATUS, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL clear_over_start got=%h exp=0", v); end
    endtask

    task automatic test_done_clear_race();
        logic [31:0] v;
        wr(A_LENGTH, 32'd1); wr(A_CTRL, 32'h1);
        @(negedge clk_i);
        misr_valid_i = 1'b1;
        addr_i = BASE + A_STATUS; data_csr_i = 32'h4; we_i = 1'b1;
        @(negedge clk_i);
        misr_valid_i = 1'b0; we_i = 1'b0;
        rd(A_STATUS, v);
        checks++;
        if (v !== 32'h6) begin failures++; $display("FAIL race_done got=%h exp=6", v); end
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        wr(A_COEFF0, POLY); wr(A_LENGTH, 32'd10); wr(A_CTRL, 32'h1);
        pulse_valid(5, 32'h0, 32'h0);
        @(negedge clk_i);
        addr_i = BASE + A_COUNT; re_i = 1'b1;
        #1;
        checks++;
        if (data_csr_o !== 32'h5) begin failures++; $display("FAIL pre_reset_count got=%h exp=5", data_csr_o); end
        rst_ni = 1'b0;
        #1;
        checks++;
        if (data_csr_o !== 32'h0) begin failures++; $display("FAIL async_count got=%h exp=0", data_csr_o); end
        re_i = 1'b0;
        rd(A_STATUS, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL async_status got=%h exp=0", v); end
        rd(A_LENGTH, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL async_length got=%h exp=0", v); end
        rd(A_COEFF0, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL async_coeff got=%h exp=0", v); end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_unmapped();
        logic [31:0] v;
        wr(A_COEFF0, POLY); wr(A_SEED0, 32'h8000_0000); wr(A_LENGTH, 32'd1);
        wr(A_CHEN, 32'h1); wr(A_CTRL, 32'h1);
        pulse_valid(1, 32'h0, 32'h0);
        wr(A_SIG0, 32'hDEAD_BEEF);
        rd(A_SIG0, v);
        checks++;
        if (v !== POLY) begin failures++; $display("FAIL sig_write_ignored got=%h exp=%h", v, POLY); end
        wr(32'h1C, 32'hFFFF_FFFF);
        rd(32'h1C, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL unmapped_1c got=%h exp=0", v); end
        rd(32'h60, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL unmapped_ch4 got=%h exp=0", v); end
        @(negedge clk_i);
        addr_i = BASE + A_LENGTH; data_csr_i = 32'd7; re_i = 1'b1; we_i = 1'b1;
        #1;
        checks++;
        if (data_csr_o !== 32'h0) begin failures++; $display("FAIL rw_both_rdata got=%h exp=0", data_csr_o); end
        @(negedge clk_i);
        re_i = 1'b0; we_i = 1'b0;
        rd(A_LENGTH, v);
        checks++;
        if (v !== 32'h7) begin failures++; $display("FAIL rw_both_write got=%h exp=7", v); end
    endtask

    initial begin
        rst_ni = 1'b0; re_i = 1'b0; we_i = 1'b0;
        addr_i = '0; data_csr_i = '0; misr_data_i = '0; misr_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        test_reset();
        test_single_step();
        test_disabled_channel();
        test_gap_irq();
        test_len0_start_clear();
        test_done_clear_race();
        test_async_reset();
        test_unmapped();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
